// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and FSM state type for the APB UART.
// No logic; constants only.
// No flow control; consumed by apb_uart_fifo and its helpers.
package apb_uart_pkg;

    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_STATUS  = 5'h01;
    localparam logic [4:0] REG_TXDATA  = 5'h02;
    localparam logic [4:0] REG_RXDATA  = 5'h03;
    localparam logic [4:0] REG_BAUDDIV = 5'h04;
    localparam logic [4:0] REG_IRQEN   = 5'h05;
    localparam logic [4:0] REG_LEVEL   = 5'h06;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_FLUSH = 2;
    localparam int CTRL_RX_FLUSH = 3;
    localparam int CTRL_PAR_EN   = 4;
    localparam int CTRL_PAR_ODD  = 5;

    localparam int STAT_RX_NEMPTY = 0;
    localparam int STAT_RX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_FULL   = 3;
    localparam int STAT_TX_BUSY   = 4;
    localparam int STAT_OVERRUN   = 5;
    localparam int STAT_PAR_ERR   = 6;
    localparam int STAT_FRM_ERR   = 7;

    localparam int IRQ_RX_NEMPTY = 0;
    localparam int IRQ_TX_EMPTY  = 1;
    localparam int IRQ_ERR       = 2;

    // Smallest divisor that still leaves a distinct mid-bit sample point.
    localparam logic [15:0] MIN_BAUDDIV = 16'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
// Latency: a push is visible on dout/empty the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB UART with TX/RX FIFOs, programmable divisor, optional parity and level irq.
// Latency: zero-wait APB; PRDATA captured on the setup edge, writes/pops on the access edge.
// Backpressure: PREADY tied high; full TX / empty RX accesses answered with PSLVERR and dropped.
module apb_uart_fifo #(
    parameter int DATAWIDTH    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DEFAULT_BAUD = 115200
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    import apb_uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RST = 16'(CLK_FREQ / DEFAULT_BAUD - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DATAWIDTH - 1);

    logic [4:0]  reg_idx;
    logic        apb_setup, wr_acc, rd_acc, slverr_next;
    logic [31:0] rdata;
    logic [7:0]  status;

    logic        tx_en, rx_en, par_en, par_odd;
    logic [2:0]  irqen;
    logic [15:0] baud_div, baud_half;
    logic [16:0] baud_p1;
    logic [DATAWIDTH-1:0] txdata_last;
    logic        overrun, par_err, frm_err;
    logic [2:0]  stat_clr;

    logic                 tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic                 rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [DATAWIDTH-1:0] tx_dout, rx_dout;
    logic [CW-1:0]        tx_count, rx_count;

    uart_state_t          tx_state, rx_state;
    logic [15:0]          tx_cnt, rx_cnt;
    logic [3:0]           tx_bit, rx_bit;
    logic [DATAWIDTH-1:0] tx_sh, rx_sh;
    logic                 tx_par, tx_par_en_q, tx_start, tx_busy;
    logic                 rx_s1, rx_s2, rx_prev;
    logic                 rx_par_bit, rx_par_en_q, rx_par_odd_q;
    logic                 rx_stop_hit, rx_ovr_set, rx_par_set, rx_frm_set;

    wire unused_bits = &{1'b0, PADDR[31:5], PWDATA[31:16]};

    assign PREADY    = 1'b1;
    assign reg_idx   = PADDR[4:0];
    assign apb_setup = PSEL && !PENABLE;
    // PSLVERR holds the setup-phase verdict, so it also vetoes the access.
    assign wr_acc    = PSEL && PENABLE && PWRITE && !PSLVERR;
    assign rd_acc    = PSEL && PENABLE && !PWRITE && !PSLVERR;

    assign tx_push  = wr_acc && (reg_idx == REG_TXDATA);
    assign tx_flush = wr_acc && (reg_idx == REG_CTRL) && PWDATA[CTRL_TX_FLUSH];
    assign rx_flush = wr_acc && (reg_idx == REG_CTRL) && PWDATA[CTRL_RX_FLUSH];
    assign rx_pop   = rd_acc && (reg_idx == REG_RXDATA);
    assign stat_clr = (wr_acc && (reg_idx == REG_STATUS)) ? PWDATA[7:5] : 3'b000;

    assign slverr_next = (PWRITE && (reg_idx == REG_TXDATA) && tx_full) ||
                         (!PWRITE && (reg_idx == REG_RXDATA) && rx_empty);

    assign tx_busy = (tx_state != S_IDLE);
    assign status  = {frm_err, par_err, overrun, tx_busy, tx_full, tx_empty, rx_full, !rx_empty};

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL: begin
                rdata[CTRL_TX_EN]   = tx_en;
                rdata[CTRL_RX_EN]   = rx_en;
                rdata[CTRL_PAR_EN]  = par_en;
                rdata[CTRL_PAR_ODD] = par_odd;
            end
            REG_STATUS:  rdata[7:0] = status;
            REG_TXDATA:  rdata[DATAWIDTH-1:0] = txdata_last;
            REG_RXDATA:  if (!rx_empty) rdata[DATAWIDTH-1:0] = rx_dout;
            REG_BAUDDIV: rdata[15:0] = baud_div;
            REG_IRQEN:   rdata[2:0] = irqen;
            REG_LEVEL: begin
                rdata[7:0]  = 8'(tx_count);
                rdata[15:8] = 8'(rx_count);
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA      <= '0;
            PSLVERR     <= 1'b0;
            tx_en       <= 1'b0;
            rx_en       <= 1'b0;
            par_en      <= 1'b0;
            par_odd     <= 1'b0;
            irqen       <= '0;
            baud_div    <= BAUD_RST;
            txdata_last <= '0;
            overrun     <= 1'b0;
            par_err     <= 1'b0;
            frm_err     <= 1'b0;
            irq         <= 1'b0;
        end else begin
            PSLVERR <= 1'b0;
            if (apb_setup) begin
                PRDATA  <= PWRITE ? 32'h0 : rdata;
                PSLVERR <= slverr_next;
            end
            if (wr_acc) begin
                case (reg_idx)
                    REG_CTRL: begin
                        tx_en   <= PWDATA[CTRL_TX_EN];
                        rx_en   <= PWDATA[CTRL_RX_EN];
                        par_en  <= PWDATA[CTRL_PAR_EN];
                        par_odd <= PWDATA[CTRL_PAR_ODD];
                    end
                    REG_TXDATA:  txdata_last <= PWDATA[DATAWIDTH-1:0];
                    REG_BAUDDIV: baud_div <= (PWDATA[15:0] < MIN_BAUDDIV) ? MIN_BAUDDIV : PWDATA[15:0];
                    REG_IRQEN:   irqen <= PWDATA[2:0];
                    default: ;
                endcase
            end
            // A set from the receiver wins over a same-cycle clear.
            overrun <= (overrun && !stat_clr[0]) || rx_ovr_set;
            par_err <= (par_err && !stat_clr[1]) || rx_par_set;
            frm_err <= (frm_err && !stat_clr[2]) || rx_frm_set;
            irq <= (irqen[IRQ_RX_NEMPTY] && !rx_empty) ||
                   (irqen[IRQ_TX_EMPTY] && tx_empty) ||
                   (irqen[IRQ_ERR] && (overrun || par_err || frm_err));
        end
    end

    uart_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .PCLK(PCLK), .PRESETn(PRESETn), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(PWDATA[DATAWIDTH-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .PCLK(PCLK), .PRESETn(PRESETn), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_sh), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign tx_start = (tx_state == S_IDLE) && tx_en && !tx_empty;
    assign tx_pop   = tx_start;

    // Divisor is re-read at every bit boundary, so BAUDDIV writes land cleanly.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state    <= S_IDLE;
            tx          <= 1'b1;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            tx_par_en_q <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            tx <= 1'b1;
            if (tx_start) begin
                tx_sh       <= tx_dout;
                tx_par      <= (^tx_dout) ^ par_odd;
                tx_par_en_q <= par_en;
                tx          <= 1'b0;
                tx_cnt      <= baud_div;
                tx_state    <= S_START;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 16'd1;
        end else begin
            tx_cnt <= baud_div;
            case (tx_state)
                S_START: begin
                    tx       <= tx_sh[0];
                    tx_bit   <= '0;
                    tx_state <= S_DATA;
                end
                S_DATA: begin
                    if (tx_bit == LAST_BIT) begin
                        tx       <= tx_par_en_q ? tx_par : 1'b1;
                        tx_state <= tx_par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        tx_sh  <= tx_sh >> 1;
                        tx     <= tx_sh[1];
                        tx_bit <= tx_bit + 4'd1;
                    end
                end
                S_PARITY: begin
                    tx       <= 1'b1;
                    tx_state <= S_STOP;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign baud_p1   = {1'b0, baud_div} + 17'd1;
    assign baud_half = baud_p1[16:1] - 16'd1;

    assign rx_stop_hit = rx_en && (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_push     = rx_stop_hit && (!rx_full || rx_pop);
    assign rx_ovr_set  = rx_stop_hit && rx_full && !rx_pop;
    assign rx_frm_set  = rx_stop_hit && !rx_s2;
    assign rx_par_set  = rx_stop_hit && rx_par_en_q && (rx_par_bit != ((^rx_sh) ^ rx_par_odd_q));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_par_bit   <= 1'b0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
        end else if (!rx_en) begin
            rx_state <= S_IDLE;
        end else if (rx_state == S_IDLE) begin
            if (rx_prev && !rx_s2) begin
                rx_state     <= S_START;
                rx_cnt       <= baud_half;
                rx_par_en_q  <= par_en;
                rx_par_odd_q <= par_odd;
            end
        end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 16'd1;
        end else begin
            rx_cnt <= baud_div;
            case (rx_state)
                S_START: begin
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    rx_sh <= {rx_s2, rx_sh[DATAWIDTH-1:1]};
                    if (rx_bit == LAST_BIT) rx_state <= rx_par_en_q ? S_PARITY : S_STOP;
                    else                    rx_bit   <= rx_bit + 4'd1;
                end
                S_PARITY: begin
                    rx_par_bit <= rx_s2;
                    rx_state   <= S_STOP;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: APB accesses queue their expected response,
// a monitor checks each access phase against the queue head.
module tb_apb_uart_fifo;

    localparam logic [4:0] R_CTRL = 5'h00, R_STATUS = 5'h01, R_TXDATA = 5'h02, R_RXDATA = 5'h03;
    localparam logic [4:0] R_BAUD = 5'h04, R_IRQEN = 5'h05, R_LEVEL = 5'h06;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        tx, irq;
    logic        loopback = 1'b0;
    logic        rx_drv = 1'b1;
    wire         rx = loopback ? tx : rx_drv;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data_q[$];
    bit          exp_dchk_q[$];
    bit          exp_err_q[$];
    string       exp_name_q[$];

    apb_uart_fifo dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every access phase consumes one scoreboard entry.
    initial begin
        logic [31:0] d;
        bit dchk, e;
        string n;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got idx 0x%0h expected none", PADDR[4:0]);
                end else begin
                    d = exp_data_q.pop_front();
                    dchk = exp_dchk_q.pop_front();
                    e = exp_err_q.pop_front();
                    n = exp_name_q.pop_front();
                    if (dchk) check(n, PRDATA, d);
                    check({n, "_pslverr"}, 32'(PSLVERR), 32'(e));
                end
            end
        end
    end

    task automatic apb_xfer(input logic [4:0] idx, input bit wr, input logic [31:0] wd,
                            input bit dchk, input logic [31:0] exp, input bit exp_err, input string name);
        exp_data_q.push_back(exp);
        exp_dchk_q.push_back(dchk);
        exp_err_q.push_back(exp_err);
        exp_name_q.push_back(name);
        @(posedge PCLK); #1;
        PADDR = {27'h400, idx};
        PWRITE = wr;
        PWDATA = wd;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [4:0] idx, input logic [31:0] wd, input bit exp_err, input string name);
        apb_xfer(idx, 1'b1, wd, 1'b0, 32'h0, exp_err, name);
    endtask

    task automatic apb_rd(input logic [4:0] idx, input logic [31:0] exp, input bit exp_err, input string name);
        apb_xfer(idx, 1'b0, 32'h0, 1'b1, exp, exp_err, name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (16) @(posedge PCLK);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, optional parity; stop bit left to caller.
    task automatic send_body(input logic [7:0] d, input bit with_par, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        #11 PRESETn = 1'b1;
        cycles(2);

        apb_rd(R_BAUD, 32'd867, 1'b0, "rst_bauddiv");
        apb_rd(R_LEVEL, 32'h0, 1'b0, "rst_level");
        apb_rd(R_STATUS, 32'h04, 1'b0, "rst_status");
        apb_rd(R_CTRL, 32'h0, 1'b0, "rst_ctrl");
        apb_rd(5'h07, 32'h0, 1'b0, "unmapped_rd");

        apb_wr(R_BAUD, 32'h1, 1'b0, "baud_wr_min");
        apb_rd(R_BAUD, 32'd3, 1'b0, "baud_clamped");
        apb_wr(R_BAUD, 32'd15, 1'b0, "baud_wr15");
        apb_rd(R_BAUD, 32'd15, 1'b0, "baud_15");

        loopback = 1'b1;
        apb_wr(R_CTRL, 32'h03, 1'b0, "ctrl_en");
        apb_wr(R_TXDATA, 32'hA5, 1'b0, "tx_a5");
        check("tx_high_on_access", 32'(tx), 32'h1);
        cycles(1);
        check("tx_start_low", 32'(tx), 32'h0);
        apb_wr(R_TXDATA, 32'h3C, 1'b0, "tx_3c");
        cycles(400);
        apb_rd(R_LEVEL, 32'h0200, 1'b0, "lb_level");
        apb_rd(R_RXDATA, 32'hA5, 1'b0, "lb_rx_a5");
        apb_rd(R_RXDATA, 32'h3C, 1'b0, "lb_rx_3c");
        apb_rd(R_STATUS, 32'h04, 1'b0, "lb_status");

        apb_wr(R_CTRL, 32'h0C, 1'b0, "ctrl_flush_dis");
        for (int i = 0; i < 16; i++) apb_wr(R_TXDATA, 32'h80 + i, 1'b0, "fill_tx");
        apb_wr(R_TXDATA, 32'hEE, 1'b1, "tx_full_wr");
        apb_rd(R_LEVEL, 32'h10, 1'b0, "full_level");
        apb_rd(R_STATUS, 32'h08, 1'b0, "full_status");
        apb_rd(R_TXDATA, 32'h8F, 1'b0, "txdata_last");
        apb_rd(R_RXDATA, 32'h0, 1'b1, "rx_empty_rd");

        apb_wr(R_CTRL, 32'h04, 1'b0, "ctrl_txflush");
        apb_rd(R_LEVEL, 32'h0, 1'b0, "flushed_level");
        apb_wr(R_CTRL, 32'h03, 1'b0, "ctrl_en2");
        for (int i = 0; i < 17; i++) apb_wr(R_TXDATA, 32'h10 + i, 1'b0, "ovr_push");
        cycles(3200);
        apb_rd(R_LEVEL, 32'h1000, 1'b0, "ovr_level");
        apb_rd(R_STATUS, 32'h27, 1'b0, "ovr_status");
        apb_wr(R_STATUS, 32'h20, 1'b0, "ovr_clear");
        apb_rd(R_STATUS, 32'h07, 1'b0, "ovr_cleared");
        apb_rd(R_RXDATA, 32'h10, 1'b0, "ovr_first");
        apb_wr(R_CTRL, 32'h0B, 1'b0, "ctrl_rxflush");
        apb_rd(R_CTRL, 32'h03, 1'b0, "ctrl_flush_rd0");
        apb_rd(R_LEVEL, 32'h0, 1'b0, "rxflush_level");

        loopback = 1'b0;
        apb_wr(R_CTRL, 32'h31, 1'b0, "ctrl_par_tx");
        apb_wr(R_TXDATA, 32'h01, 1'b0, "tx_par01");
        cycles(1);
        check("par_start", 32'(tx), 32'h0);
        cycles(23);
        check("par_d0", 32'(tx), 32'h1);
        cycles(128);
        check("par_bit_odd", 32'(tx), 32'h0);
        cycles(16);
        check("par_stop", 32'(tx), 32'h1);
        cycles(40);

        apb_wr(R_CTRL, 32'h32, 1'b0, "ctrl_par_rx");
        apb_wr(R_IRQEN, 32'h4, 1'b0, "irqen_err");
        cycles(2);
        send_body(8'h01, 1'b1, 1'b1);
        check("irq_before_stop", 32'(irq), 32'h0);
        drive_bit(1'b1);
        check("irq_par_err", 32'(irq), 32'h1);
        apb_rd(R_STATUS, 32'h45, 1'b0, "par_status");
        apb_rd(R_RXDATA, 32'h01, 1'b0, "par_data");
        apb_wr(R_STATUS, 32'h40, 1'b0, "par_clear");
        cycles(3);
        check("irq_cleared", 32'(irq), 32'h0);

        apb_wr(R_CTRL, 32'h02, 1'b0, "ctrl_rx_only");
        send_body(8'h5A, 1'b0, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        apb_rd(R_STATUS, 32'h85, 1'b0, "frm_status");
        check("irq_frm", 32'(irq), 32'h1);
        apb_rd(R_RXDATA, 32'h5A, 1'b0, "frm_data");
        apb_wr(R_STATUS, 32'h80, 1'b0, "frm_clear");

        rx_drv = 1'b0;
        repeat (5) @(posedge PCLK);
        #1 rx_drv = 1'b1;
        cycles(200);
        apb_rd(R_LEVEL, 32'h0, 1'b0, "glitch_level");
        apb_rd(R_STATUS, 32'h04, 1'b0, "glitch_status");

        cycles(4);
        check("scoreboard_drained", 32'(exp_data_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
